// File: rtl/adc_scan_ctrl.sv
// Scanning controller for a mux-input ADC: walks an enabled channel mask, averages
// 2^AVG_LOG2 samples per channel and keeps one averaged result per channel for readback.
module adc_scan_ctrl #(
    parameter int DATA_W   = 12,
    parameter int CH_NUM   = 16,
    parameter int CH_W     = 4,
    parameter int AVG_LOG2 = 2,
    parameter int SETTLE   = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Mode,
    input  logic [CH_NUM-1:0] Ch_Mask,
    output logic [CH_W-1:0]   ADC_CH,
    output logic              ADC_CONV,
    output logic              ADC_RD,
    input  logic [DATA_W-1:0] ADC_DATA,
    input  logic              ADC_STS,
    output logic              Busy,
    output logic              Result_Valid,
    output logic [CH_W-1:0]   Result_Ch,
    output logic [DATA_W-1:0] Result_Data,
    output logic              Timeout_Err,
    input  logic [CH_W-1:0]   Rd_Ch,
    output logic [DATA_W-1:0] Rd_Data
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int WT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] N_AVG = CNT_W'(1 << AVG_LOG2);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_CONV, S_WAIT, S_READ, S_ACC, S_NEXT
    } state_t;

    state_t state, state_nx;

    logic              mode_q;
    logic [CH_NUM-1:0] mask_q;
    logic              stop_flag;
    logic [SET_W-1:0]  settle_cnt;
    logic [WT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]  sample_cnt;
    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] res_mem [CH_NUM];

    // Lowest enabled channel at or above 'from'; MSB flags that one was found.
    function automatic logic [CH_W:0] first_en(input logic [CH_NUM-1:0] m, input int from);
        logic [CH_W:0] r;
        r = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (m[i] && i >= from) r = {1'b1, CH_W'(i)};
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] s;
        s = a >> AVG_LOG2;
        return s[DATA_W-1:0];
    endfunction

    logic [CH_W:0]     start_en, low_en, nxt_en;
    logic              start_ok, timeout_hit, avg_done, stop_now;
    logic [DATA_W-1:0] avg_val;

    assign start_en    = first_en(Ch_Mask, 0);
    assign low_en      = first_en(mask_q, 0);
    assign nxt_en      = first_en(mask_q, int'(ADC_CH) + 1);
    assign start_ok    = Start && (Ch_Mask != '0);
    assign timeout_hit = (state == S_WAIT) && ADC_STS && (wait_cnt == WT_W'(TIMEOUT - 1));
    assign avg_done    = (sample_cnt == N_AVG);
    assign stop_now    = stop_flag || Stop;
    assign avg_val     = avg_trunc(acc);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ADC_CONV = 1'b0;
        ADC_RD   = 1'b0;
        Busy     = (state != S_IDLE);
        case (state)
            S_IDLE:   if (start_ok) state_nx = S_SETTLE;
            S_SETTLE: if (settle_cnt == SET_W'(SETTLE - 1)) state_nx = S_CONV;
            S_CONV: begin
                ADC_CONV = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (!ADC_STS)        state_nx = S_READ;
                else if (timeout_hit) state_nx = S_NEXT;
            end
            S_READ: begin
                ADC_RD   = 1'b1;
                state_nx = S_ACC;
            end
            S_ACC:    state_nx = avg_done ? S_NEXT : S_CONV;
            S_NEXT: begin
                if (stop_now)            state_nx = S_IDLE;
                else if (nxt_en[CH_W])   state_nx = S_SETTLE;
                else if (mode_q)         state_nx = S_SETTLE;
                else                     state_nx = S_IDLE;
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            mode_q       <= 1'b0;
            mask_q       <= '0;
            stop_flag    <= 1'b0;
            settle_cnt   <= '0;
            wait_cnt     <= '0;
            sample_cnt   <= '0;
            acc          <= '0;
            ADC_CH       <= '0;
            Result_Valid <= 1'b0;
            Result_Ch    <= '0;
            Result_Data  <= '0;
            Timeout_Err  <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) res_mem[i] <= '0;
        end else begin
            Result_Valid <= 1'b0;
            settle_cnt   <= (state == S_SETTLE) ? settle_cnt + SET_W'(1) : '0;
            wait_cnt     <= (state == S_WAIT)   ? wait_cnt + WT_W'(1)    : '0;
            if (state != S_IDLE && Stop) stop_flag <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        mode_q      <= Mode;
                        mask_q      <= Ch_Mask;
                        Timeout_Err <= 1'b0;
                        stop_flag   <= 1'b0;
                        ADC_CH      <= start_en[CH_W-1:0];
                        acc         <= '0;
                        sample_cnt  <= '0;
                    end
                end
                // A timed-out channel drops its partial average entirely.
                S_WAIT: begin
                    if (timeout_hit) begin
                        Timeout_Err <= 1'b1;
                        acc         <= '0;
                        sample_cnt  <= '0;
                    end
                end
                S_READ: begin
                    acc        <= acc + ACC_W'(ADC_DATA);
                    sample_cnt <= sample_cnt + CNT_W'(1);
                end
                S_ACC: begin
                    if (avg_done) begin
                        res_mem[ADC_CH] <= avg_val;
                        Result_Valid    <= 1'b1;
                        Result_Ch       <= ADC_CH;
                        Result_Data     <= avg_val;
                        acc             <= '0;
                        sample_cnt      <= '0;
                    end
                end
                // In single-scan mode ADC_CH keeps the last channel once the mask is exhausted.
                S_NEXT: begin
                    if (!stop_now) begin
                        if (nxt_en[CH_W])  ADC_CH <= nxt_en[CH_W-1:0];
                        else if (mode_q)   ADC_CH <= low_en[CH_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        Rd_Data = '0;
        if (int'(Rd_Ch) < CH_NUM) Rd_Data = res_mem[Rd_Ch];
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Randomized bench for adc_scan_ctrl: a behavioural ADC plus a scoreboard that predicts
// channel order, per-channel averages and readback contents from the scan rules.
module tb_adc_scan_ctrl;

    localparam int DATA_W   = 12;
    localparam int CH_NUM   = 16;
    localparam int CH_W     = 4;
    localparam int AVG_LOG2 = 2;
    localparam int SETTLE   = 4;
    localparam int TIMEOUT  = 1023;
    localparam int N_AVG    = 1 << AVG_LOG2;

    logic              CLK = 1'b0;
    logic              RSTn = 1'b0;
    logic              Start = 1'b0;
    logic              Stop = 1'b0;
    logic              Mode = 1'b0;
    logic [CH_NUM-1:0] Ch_Mask = '0;
    logic [CH_W-1:0]   ADC_CH;
    logic              ADC_CONV;
    logic              ADC_RD;
    logic [DATA_W-1:0] ADC_DATA = '0;
    logic              ADC_STS = 1'b0;
    logic              Busy;
    logic              Result_Valid;
    logic [CH_W-1:0]   Result_Ch;
    logic [DATA_W-1:0] Result_Data;
    logic              Timeout_Err;
    logic [CH_W-1:0]   Rd_Ch = '0;
    logic [DATA_W-1:0] Rd_Data;

    adc_scan_ctrl #(
        .DATA_W(DATA_W), .CH_NUM(CH_NUM), .CH_W(CH_W),
        .AVG_LOG2(AVG_LOG2), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .Start(Start), .Stop(Stop), .Mode(Mode),
        .Ch_Mask(Ch_Mask), .ADC_CH(ADC_CH), .ADC_CONV(ADC_CONV), .ADC_RD(ADC_RD),
        .ADC_DATA(ADC_DATA), .ADC_STS(ADC_STS), .Busy(Busy),
        .Result_Valid(Result_Valid), .Result_Ch(Result_Ch), .Result_Data(Result_Data),
        .Timeout_Err(Timeout_Err), .Rd_Ch(Rd_Ch), .Rd_Data(Rd_Data)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference state
    logic [CH_NUM-1:0] exp_mask = '0;
    int exp_ch = 0;
    int exp_mem [CH_NUM];
    int pend [$];
    int got_ch [$];
    int res_cnt = 0, conv_cnt = 0, rd_cnt = 0, conv_since = 0;
    int cyc = 0, conv_cyc = 0;

    // ADC behaviour
    int  dly_lo = 1, dly_hi = 8;
    bit  hang = 1'b0;
    int  cnt = 0;
    int  force_q [$];

    // Next enabled channel after 'cur', wrapping round the channel ring.
    function automatic int next_en(input logic [CH_NUM-1:0] m, input int cur);
        for (int k = 1; k <= CH_NUM; k++) begin
            if (m[(cur + k) % CH_NUM]) return (cur + k) % CH_NUM;
        end
        return cur;
    endfunction

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin : mon
        int sum;
        if (RSTn) begin
            if (ADC_CONV) begin
                conv_cnt++;
                conv_since++;
                conv_cyc = cyc;
                chk("conv_ch", int'(ADC_CH), exp_ch);
                ADC_STS = 1'b1;
                cnt = int'($urandom_range(dly_hi, dly_lo));
            end else if (cnt > 0 && !hang) begin
                cnt--;
                if (cnt == 0) begin
                    ADC_STS = 1'b0;
                    if (force_q.size() > 0) ADC_DATA = DATA_W'(force_q.pop_front());
                    else                    ADC_DATA = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
                end
            end
            if (ADC_RD) begin
                rd_cnt++;
                pend.push_back(int'(ADC_DATA));
            end
            if (Result_Valid) begin
                sum = 0;
                foreach (pend[i]) sum += pend[i];
                chk("res_nsamp", pend.size(), N_AVG);
                chk("res_nconv", conv_since, N_AVG);
                chk("res_ch", int'(Result_Ch), exp_ch);
                chk("res_data", int'(Result_Data), sum / N_AVG);
                exp_mem[exp_ch] = sum / N_AVG;
                got_ch.push_back(int'(Result_Ch));
                res_cnt++;
                conv_since = 0;
                pend.delete();
                exp_ch = next_en(exp_mask, exp_ch);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_start(input logic [CH_NUM-1:0] m, input logic md);
        exp_mask   = m;
        exp_ch     = next_en(m, CH_NUM - 1);
        res_cnt    = 0;
        conv_cnt   = 0;
        rd_cnt     = 0;
        conv_since = 0;
        got_ch.delete();
        Start   = 1'b1;
        Ch_Mask = m;
        Mode    = md;
        @(negedge CLK);
        Start = 1'b0;
        chk("busy_after_start", int'(Busy), 1);
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (Busy && n < maxc) begin
            @(negedge CLK);
            n++;
        end
        chk("scan_end", int'(Busy), 0);
    endtask

    task automatic wait_res(input int k, input int maxc);
        int n = 0;
        while (res_cnt < k && n < maxc) begin
            @(negedge CLK);
            n++;
        end
        chk("wait_results", res_cnt, k);
    endtask

    task automatic wait_conv(input int maxc);
        int n = 0;
        while (!ADC_CONV && n < maxc) begin
            @(negedge CLK);
            n++;
        end
        chk("wait_conv", int'(ADC_CONV), 1);
    endtask

    task automatic readback();
        for (int c = 0; c < CH_NUM; c++) begin
            Rd_Ch = CH_W'(c);
            #1;
            chk($sformatf("rd_ch%0d", c), int'(Rd_Data), exp_mem[c]);
        end
        @(negedge CLK);
    endtask

    task automatic stop_scan(input logic [CH_NUM-1:0] m, input int k);
        do_start(m, 1'b1);
        wait_res(k, 20000);
        wait_conv(500);
        Stop = 1'b1;
        @(negedge CLK);
        Stop = 1'b0;
        wait_idle(2000);
        chk("stop_results", res_cnt, k + 1);
    endtask

    initial begin
        logic [CH_NUM-1:0] m;
        int base;
        for (int c = 0; c < CH_NUM; c++) exp_mem[c] = 0;

        // Reset state
        tick(3);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_adc_ch", int'(ADC_CH), 0);
        chk("rst_conv", int'(ADC_CONV), 0);
        chk("rst_rd", int'(ADC_RD), 0);
        chk("rst_rv", int'(Result_Valid), 0);
        chk("rst_rdata", int'(Result_Data), 0);
        chk("rst_tmo", int'(Timeout_Err), 0);
        readback();
        RSTn = 1'b1;
        tick(2);

        // Single channel 2, constant data 5, 600 ns conversion time
        dly_lo = 60; dly_hi = 60;
        repeat (4) force_q.push_back(5);
        do_start(16'h0004, 1'b0);
        wait_idle(2000);
        chk("t1_conv", conv_cnt, 4);
        chk("t1_rd", rd_cnt, 4);
        chk("t1_results", res_cnt, 1);
        chk("t1_res_ch", int'(Result_Ch), 2);
        chk("t1_res_data", int'(Result_Data), 5);
        chk("t1_adc_ch_hold", int'(ADC_CH), 2);
        readback();

        // Truncating average: 10+11+12+14 = 47 -> 11
        dly_lo = 1; dly_hi = 4;
        force_q = '{10, 11, 12, 14};
        do_start(16'h0001, 1'b0);
        wait_idle(2000);
        chk("t2_avg", int'(Result_Data), 11);
        readback();

        // Continuous 0x8001 with Stop during the second pass over channel 15
        dly_lo = 1; dly_hi = 6;
        stop_scan(16'h8001, 3);
        chk("t3_order0", got_ch[0], 0);
        chk("t3_order1", got_ch[1], 15);
        chk("t3_order2", got_ch[2], 0);
        chk("t3_order3", got_ch[3], 15);

        // Timeout on a channel that never becomes ready
        hang = 1'b1;
        do_start(16'h0010, 1'b0);
        begin
            int n = 0;
            while (!Timeout_Err && n < 3000) begin
                @(negedge CLK);
                n++;
            end
        end
        chk("tmo_set", int'(Timeout_Err), 1);
        chk("tmo_latency", cyc - conv_cyc, TIMEOUT + 1);
        wait_idle(50);
        chk("tmo_no_rd", rd_cnt, 0);
        chk("tmo_no_result", res_cnt, 0);
        chk("tmo_sticky", int'(Timeout_Err), 1);
        hang = 1'b0;
        tick(12);
        do_start(16'h0010, 1'b0);
        chk("tmo_cleared", int'(Timeout_Err), 0);
        wait_idle(2000);
        chk("tmo_rescan", res_cnt, 1);

        // Start with an empty mask is ignored
        base = conv_cnt;
        Ch_Mask = '0;
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        chk("mask0_busy", int'(Busy), 0);
        tick(10);
        chk("mask0_busy_late", int'(Busy), 0);
        chk("mask0_no_conv", conv_cnt, base);

        // Start while busy leaves mask and mode alone
        do_start(16'h0003, 1'b0);
        wait_conv(100);
        Ch_Mask = 16'h0100;
        Mode    = 1'b1;
        Start   = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        wait_idle(2000);
        chk("busy_start_results", res_cnt, 2);
        readback();

        // Random single scans
        for (int r = 0; r < 6; r++) begin
            m = CH_NUM'($urandom_range(1, (1 << CH_NUM) - 1));
            dly_lo = 1; dly_hi = int'($urandom_range(2, 10));
            do_start(m, 1'b0);
            wait_idle(20000);
            chk("rand_results", res_cnt, $countones(m));
        end
        readback();

        // Random continuous scans ended by Stop
        for (int r = 0; r < 3; r++) begin
            m = CH_NUM'($urandom_range(1, (1 << CH_NUM) - 1));
            stop_scan(m, int'($urandom_range(1, 6)));
        end
        readback();

        // Reset in the middle of WAIT
        hang = 1'b1;
        do_start(16'h0040, 1'b0);
        wait_conv(100);
        tick(5);
        #2 RSTn = 1'b0;
        #1;
        chk("mid_rst_busy", int'(Busy), 0);
        chk("mid_rst_adc_ch", int'(ADC_CH), 0);
        chk("mid_rst_rv", int'(Result_Valid), 0);
        chk("mid_rst_rdata", int'(Result_Data), 0);
        chk("mid_rst_rch", int'(Result_Ch), 0);
        for (int c = 0; c < CH_NUM; c++) exp_mem[c] = 0;
        readback();
        RSTn = 1'b1;
        hang = 1'b0;
        pend.delete();
        tick(12);
        m = CH_NUM'($urandom_range(1, (1 << CH_NUM) - 1));
        do_start(m, 1'b0);
        wait_idle(20000);
        chk("post_rst_results", res_cnt, $countones(m));
        readback();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
